// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package instruction_fetch_unit_pkg;

  localparam int unsigned IFU_ADDR_WIDTH = 8;
  localparam int unsigned IFU_DATA_WIDTH = 16;

  // Reset/restart address and the encoding that ends execution (shared with the decoder)
  localparam logic [IFU_ADDR_WIDTH-1:0] IFU_RESET_PC  = 8'h00;
  localparam logic [IFU_DATA_WIDTH-1:0] IFU_HALT_WORD = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_DONE  = 2'd3
  } ifu_state_t;

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// rtl/instruction_fetch_unit_program_counter.sv - program counter with load, increment and rollover flag
module instruction_fetch_unit_program_counter
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH = IFU_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = IFU_RESET_PC
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_value,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  wrap
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_wrap;

  // Load wins over increment; wrap only flags a rollover caused by increment, never by a load
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pc   <= RESET_PC;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_pc   <= load_value;
      r_wrap <= 1'b0;
    end else if (inc) begin
      r_pc   <= r_pc + 1'b1;
      r_wrap <= (r_pc == {ADDR_WIDTH{1'b1}});
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign pc   = r_pc;
  assign wrap = r_wrap;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - sequential fetcher feeding the IR to the control unit over valid/ready
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH = IFU_ADDR_WIDTH,
  parameter int unsigned             DATA_WIDTH = IFU_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = IFU_RESET_PC,
  parameter logic [DATA_WIDTH-1:0]   HALT_WORD  = IFU_HALT_WORD
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] ir,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  done,
  output logic                  wrap
);

  ifu_state_t            r_state;
  ifu_state_t            w_next_state;
  logic [DATA_WIDTH-1:0] r_ir;
  logic                  r_ir_valid;
  logic                  r_done;
  logic                  w_ir_valid_next;
  logic                  w_ir_load;
  logic                  w_pc_load;
  logic [ADDR_WIDTH-1:0] w_pc_load_value;
  logic                  w_pc_inc;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_pc;

  assign w_accept = r_ir_valid && ir_ready;

  instruction_fetch_unit_program_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_program_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (w_pc_load),
    .load_value (w_pc_load_value),
    .inc        (w_pc_inc),
    .pc         (w_pc),
    .wrap       (wrap)
  );

  // Next state and datapath controls; pause overrides everything in FETCH/VALID but never drops an accept
  always_comb begin
    w_next_state    = r_state;
    w_ir_valid_next = r_ir_valid;
    w_ir_load       = 1'b0;
    w_pc_load       = 1'b0;
    w_pc_load_value = w_pc;
    w_pc_inc        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ir_valid_next = 1'b0;
        if (start) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        if (pause) begin
          w_ir_valid_next = 1'b0;
          w_next_state    = S_IDLE;
        end else begin
          w_ir_load       = 1'b1;
          w_pc_inc        = 1'b1;
          w_ir_valid_next = 1'b1;
          w_next_state    = S_VALID;
        end
      end
      S_VALID: begin
        if (pause) begin
          w_ir_valid_next = 1'b0;
          w_next_state    = S_IDLE;
        end else if (w_accept) begin
          if (r_ir == HALT_WORD) begin
            w_ir_valid_next = 1'b0;
            w_next_state    = S_DONE;
          end else if (jump_en) begin
            w_ir_valid_next = 1'b0;
            w_pc_load       = 1'b1;
            w_pc_load_value = jump_addr;
            w_next_state    = S_FETCH;
          end else begin
            w_ir_load = 1'b1;
            w_pc_inc  = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_ir_valid_next = 1'b0;
        if (start) begin
          w_pc_load       = 1'b1;
          w_pc_load_value = RESET_PC;
          w_next_state    = S_FETCH;
        end
      end
      default: begin
        w_ir_valid_next = 1'b0;
        w_next_state    = S_IDLE;
      end
    endcase
  end

  // State, IR and registered status flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_ir_valid <= w_ir_valid_next;
      r_done     <= (w_next_state == S_DONE);
      if (w_ir_load) r_ir <= instruction;
    end
  end

  assign address  = w_pc;
  assign pc       = w_pc;
  assign ir       = r_ir;
  assign ir_valid = r_ir_valid;
  assign done     = r_done;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        pause;
  logic [7:0]  address;
  logic [15:0] instruction;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic [7:0]  pc;
  logic        done;
  logic        wrap;

  logic [15:0] rom [256];
  int          n_checks = 0;
  int          n_pass   = 0;

  instruction_fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .address     (address),
    .instruction (instruction),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .pc          (pc),
    .done        (done),
    .wrap        (wrap)
  );

  assign instruction = rom[address];

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [15:0] e_ir, input logic e_valid,
                             input logic [7:0] e_pc, input logic e_done, input logic e_wrap);
    check({tag, ".ir"},       32'(ir),       32'(e_ir));
    check({tag, ".ir_valid"}, 32'(ir_valid), 32'(e_valid));
    check({tag, ".pc"},       32'(pc),       32'(e_pc));
    check({tag, ".address"},  32'(address),  32'(e_pc));
    check({tag, ".done"},     32'(done),     32'(e_done));
    check({tag, ".wrap"},     32'(wrap),     32'(e_wrap));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0100 | 16'(i);
    rom[8'h00] = 16'h1111;
    rom[8'h01] = 16'h2222;
    rom[8'h02] = 16'h3333;
    rom[8'h03] = 16'h4444;
    rom[8'h04] = 16'h5555;
    rom[8'h05] = 16'hFFFF;
    rom[8'h40] = 16'hABCD;
    rom[8'hFE] = 16'hFE01;
    rom[8'hFF] = 16'hFF02;

    reset = 1'b0; start = 1'b0; pause = 1'b0; ir_ready = 1'b0; jump_en = 1'b0; jump_addr = 8'h00;
    step(); step();
    check_state("reset", 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    step();

    // start, stream back-to-back into the halt word
    ir_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check_state("fetch_bubble", 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
    step(); check_state("s0", 16'h1111, 1'b1, 8'h01, 1'b0, 1'b0);
    step(); check_state("s1", 16'h2222, 1'b1, 8'h02, 1'b0, 1'b0);
    step(); check_state("s2", 16'h3333, 1'b1, 8'h03, 1'b0, 1'b0);
    step(); check_state("s3", 16'h4444, 1'b1, 8'h04, 1'b0, 1'b0);
    step(); check_state("s4", 16'h5555, 1'b1, 8'h05, 1'b0, 1'b0);
    step(); check_state("s5", 16'hFFFF, 1'b1, 8'h06, 1'b0, 1'b0);
    // jump request alongside the halt word must be ignored
    jump_en = 1'b1; jump_addr = 8'h40;
    step();
    jump_en = 1'b0;
    check_state("halt", 16'hFFFF, 1'b0, 8'h06, 1'b1, 1'b0);
    ir_ready = 1'b0;
    step(); check_state("halt_hold", 16'hFFFF, 1'b0, 8'h06, 1'b1, 1'b0);

    // restart from DONE
    start = 1'b1;
    step();
    start = 1'b0;
    check_state("restart", 16'hFFFF, 1'b0, 8'h00, 1'b0, 1'b0);
    step(); check_state("restart_ir", 16'h1111, 1'b1, 8'h01, 1'b0, 1'b0);
    ir_ready = 1'b1;
    step(); check_state("r1", 16'h2222, 1'b1, 8'h02, 1'b0, 1'b0);

    // backpressure
    ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_state("stall", 16'h2222, 1'b1, 8'h02, 1'b0, 1'b0);
    end
    ir_ready = 1'b1;
    step(); check_state("after_stall", 16'h3333, 1'b1, 8'h03, 1'b0, 1'b0);

    // jump to 0x40
    jump_en = 1'b1; jump_addr = 8'h40;
    step();
    jump_en = 1'b0;
    check_state("jump_bubble", 16'h3333, 1'b0, 8'h40, 1'b0, 1'b0);
    step(); check_state("jump_ir", 16'hABCD, 1'b1, 8'h41, 1'b0, 1'b0);

    // jump to 0xFE and stream across the rollover
    jump_en = 1'b1; jump_addr = 8'hFE;
    step();
    jump_en = 1'b0;
    check_state("jfe_bubble", 16'hABCD, 1'b0, 8'hFE, 1'b0, 1'b0);
    step(); check_state("wfe", 16'hFE01, 1'b1, 8'hFF, 1'b0, 1'b0);
    step(); check_state("wff", 16'hFF02, 1'b1, 8'h00, 1'b0, 1'b1);
    step(); check_state("w00", 16'h1111, 1'b1, 8'h01, 1'b0, 1'b0);

    // jump to 0x00 must not flag wrap
    jump_en = 1'b1; jump_addr = 8'h00;
    step();
    jump_en = 1'b0;
    check_state("j00", 16'h1111, 1'b0, 8'h00, 1'b0, 1'b0);
    step(); check_state("j00_ir", 16'h1111, 1'b1, 8'h01, 1'b0, 1'b0);

    // pause with a simultaneous accept: consumed, nothing new loaded, pc held
    pause = 1'b1;
    step();
    pause = 1'b0;
    check_state("pause", 16'h1111, 1'b0, 8'h01, 1'b0, 1'b0);
    step(); check_state("paused_idle", 16'h1111, 1'b0, 8'h01, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); check_state("resume", 16'h2222, 1'b1, 8'h02, 1'b0, 1'b0);

    // reset during VALID discards the pending word
    ir_ready = 1'b0; reset = 1'b0;
    step();
    check_state("mid_reset", 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    step(); check_state("post_reset_idle", 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
